// File: rtl/vga_timing_pkg.sv
// Shared raster constants and coordinate type for the VGA timing generator.
// Defaults describe 640x480@60 on a 25 MHz pixel rate.
package vga_timing_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam int H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    localparam int CNT_W = $clog2((H_TOTAL > V_TOTAL) ? H_TOTAL : V_TOTAL);

    typedef logic [CNT_W-1:0] coord_t;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with registered sync, active
// flag and masked coordinate, all decoded from the next count value.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int ACTIVE = DEF_H_ACTIVE,
    parameter int FP     = DEF_H_FP,
    parameter int SYNC   = DEF_H_SYNC,
    parameter int BP     = DEF_H_BP
) (
    input  logic   clk_in,
    input  logic   reset,
    input  logic   en,
    output coord_t count,
    output logic   wrap,
    output logic   sync_n,
    output logic   in_active,
    output logic   in_active_nxt,
    output coord_t coord
);

    localparam int     TOTAL   = ACTIVE + FP + SYNC + BP;
    localparam coord_t LAST    = coord_t'(TOTAL - 1);
    localparam coord_t SYNC_LO = coord_t'(ACTIVE + FP);
    localparam coord_t SYNC_HI = coord_t'(ACTIVE + FP + SYNC);
    localparam coord_t ACT_END = coord_t'(ACTIVE);

    coord_t count_nxt;

    assign wrap          = en && (count == LAST);
    assign count_nxt     = wrap ? '0 : count + 1'b1;
    // Lets the parent register a combined flag on the same edge as the count.
    assign in_active_nxt = en ? (count_nxt < ACT_END) : in_active;

    always_ff @(posedge clk_in) begin
        if (reset) begin
            count     <= LAST;
            sync_n    <= 1'b1;
            in_active <= 1'b0;
            coord     <= '0;
        end else if (en) begin
            count     <= count_nxt;
            sync_n    <= !((count_nxt >= SYNC_LO) && (count_nxt < SYNC_HI));
            in_active <= (count_nxt < ACT_END);
            coord     <= (count_nxt < ACT_END) ? count_nxt : '0;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing top: horizontal/vertical axis counters, registered event
// pulses and vblank-aligned buffer swap acknowledgement.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP
) (
    input  logic               clk_in,
    input  logic               reset,
    input  logic               pix_tick,
    input  logic               swap_req,
    output logic               hsync,
    output logic               vsync,
    output logic               active,
    output logic [CNT_W-1:0]   x,
    output logic [CNT_W-1:0]   y,
    output logic               line_start,
    output logic               frame_start,
    output logic               vblank_start,
    output logic               swap_ack
);

    coord_t h_cnt, v_cnt;
    logic   h_wrap, v_wrap;
    logic   h_act, v_act, h_act_nxt, v_act_nxt;
    logic   v_en, vblank_hit;
    logic   unused_axis;

    assign v_en = pix_tick && h_wrap;

    vga_axis_counter #(
        .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)
    ) u_h_axis (
        .clk_in        (clk_in),
        .reset         (reset),
        .en            (pix_tick),
        .count         (h_cnt),
        .wrap          (h_wrap),
        .sync_n        (hsync),
        .in_active     (h_act),
        .in_active_nxt (h_act_nxt),
        .coord         (x)
    );

    vga_axis_counter #(
        .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)
    ) u_v_axis (
        .clk_in        (clk_in),
        .reset         (reset),
        .en            (v_en),
        .count         (v_cnt),
        .wrap          (v_wrap),
        .sync_n        (vsync),
        .in_active     (v_act),
        .in_active_nxt (v_act_nxt),
        .coord         (y)
    );

    assign unused_axis = ^{h_cnt, h_act, v_act};

    // This tick closes the last visible line, so the next position is vblank entry.
    assign vblank_hit = v_en && (v_cnt == coord_t'(V_ACTIVE - 1));

    always_ff @(posedge clk_in) begin
        if (reset) begin
            active       <= 1'b0;
            line_start   <= 1'b0;
            frame_start  <= 1'b0;
            vblank_start <= 1'b0;
            swap_ack     <= 1'b0;
        end else begin
            active       <= h_act_nxt && v_act_nxt;
            line_start   <= v_en;
            frame_start  <= v_en && v_wrap;
            vblank_start <= vblank_hit;
            swap_ack     <= vblank_hit && swap_req;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen using a reduced raster (15 x 13) so that
// whole frames fit in a short run; expectations come from a position model.
module tb_vga_timing_gen;

    localparam int HA = 8, HF = 2, HS = 3, HB = 2;
    localparam int VA = 6, VF = 2, VS = 2, VB = 3;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam logic [26:0] RST_VEC   = {2'b11, 25'd0};
    localparam logic [26:0] FIRST_VEC = {3'b111, 20'd0, 4'b1100};

    logic       clk_in = 1'b0;
    logic       reset = 1'b1;
    logic       pix_tick = 1'b0;
    logic       swap_req = 1'b0;
    logic       hsync, vsync, active;
    logic [9:0] x, y;
    logic       line_start, frame_start, vblank_start, swap_ack;

    int vectors = 0;
    int miscompares = 0;
    int th = HT - 1;
    int tv = VT - 1;
    int cyc = 0;
    int fs_cyc = 0;

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) dut (
        .clk_in       (clk_in),
        .reset        (reset),
        .pix_tick     (pix_tick),
        .swap_req     (swap_req),
        .hsync        (hsync),
        .vsync        (vsync),
        .active       (active),
        .x            (x),
        .y            (y),
        .line_start   (line_start),
        .frame_start  (frame_start),
        .vblank_start (vblank_start),
        .swap_ack     (swap_ack)
    );

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc <= cyc + 1;

    wire [26:0] obs = {hsync, vsync, active, x, y,
                       line_start, frame_start, vblank_start, swap_ack};

    function automatic logic [26:0] exp_vec(int h, int v, bit tk, bit rq);
        logic hs, vs, act, ls, fs, vb, ak;
        logic [9:0] xx, yy;
        hs  = !((h >= HA + HF) && (h < HA + HF + HS));
        vs  = !((v >= VA + VF) && (v < VA + VF + VS));
        act = (h < HA) && (v < VA);
        xx  = (h < HA) ? 10'(h) : 10'd0;
        yy  = (v < VA) ? 10'(v) : 10'd0;
        ls  = tk && (h == 0);
        fs  = ls && (v == 0);
        vb  = ls && (v == VA);
        ak  = vb && rq;
        return {hs, vs, act, xx, yy, ls, fs, vb, ak};
    endfunction

    task automatic drive(input bit tk, input bit rs);
        @(negedge clk_in);
        pix_tick = tk;
        reset    = rs;
        @(posedge clk_in);
        #1;
        if (rs) begin
            th = HT - 1;
            tv = VT - 1;
        end else if (tk) begin
            if (th == HT - 1) begin
                th = 0;
                tv = (tv == VT - 1) ? 0 : tv + 1;
            end else begin
                th = th + 1;
            end
        end
    endtask

    task automatic test_reset();
        logic [26:0] e;
        drive(0, 1);
        drive(1, 1);
        vectors++;
        if (obs !== RST_VEC) begin
            miscompares++;
            $display("FAIL reset_values: got %h expected %h", obs, RST_VEC);
        end
        drive(1, 0);
        fs_cyc = cyc;
        vectors++;
        if (obs !== FIRST_VEC) begin
            miscompares++;
            $display("FAIL first_tick: got %h expected %h", obs, FIRST_VEC);
        end
        drive(0, 0);
        e = exp_vec(th, tv, 0, 0);
        vectors++;
        if (obs !== e) begin
            miscompares++;
            $display("FAIL pulse_one_cycle: got %h expected %h", obs, e);
        end
    endtask

    task automatic test_frame();
        logic [26:0] e;
        int hs_low = 0, vs_low = 0, ls_n = 0, vb_n = 0, next_fs = -1;
        for (int i = 0; i < HT * VT; i++) begin
            drive(1, 0);
            e = exp_vec(th, tv, 1, 0);
            vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL frame_tick h=%0d v=%0d: got %h expected %h", th, tv, obs, e);
            end
            if (!hsync) hs_low++;
            if (!vsync) vs_low++;
            if (line_start) ls_n++;
            if (vblank_start) vb_n++;
            if (frame_start) next_fs = cyc;
            drive(0, 0);
            e = exp_vec(th, tv, 0, 0);
            vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL frame_idle h=%0d v=%0d: got %h expected %h", th, tv, obs, e);
            end
        end
        vectors++;
        if (hs_low != HS * VT) begin
            miscompares++;
            $display("FAIL hsync_low_ticks: got %0d expected %0d", hs_low, HS * VT);
        end
        vectors++;
        if (vs_low != VS * HT) begin
            miscompares++;
            $display("FAIL vsync_low_ticks: got %0d expected %0d", vs_low, VS * HT);
        end
        vectors++;
        if (ls_n != VT || vb_n != 1) begin
            miscompares++;
            $display("FAIL pulse_counts: got line=%0d vblank=%0d expected %0d/1", ls_n, vb_n, VT);
        end
        vectors++;
        if (next_fs - fs_cyc != 2 * HT * VT) begin
            miscompares++;
            $display("FAIL frame_period: got %0d expected %0d", next_fs - fs_cyc, 2 * HT * VT);
        end
    endtask

    task automatic test_swap();
        logic [26:0] e;
        int acks = 0, waited = 0, guard = 0;
        bit seen = 0;
        while (tv != 2) drive(1, 0);
        swap_req = 1'b1;
        while (!(th == 0 && tv == VA + VF + VS + 1) && guard < 2 * HT * VT) begin
            guard++;
            drive(1, 0);
            e = exp_vec(th, tv, 1, swap_req);
            vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL swap_tick h=%0d v=%0d: got %h expected %h", th, tv, obs, e);
            end
            if (swap_ack) begin
                acks++;
                swap_req = 1'b0;
            end
            drive(0, 0);
        end
        vectors++;
        if (acks != 1) begin
            miscompares++;
            $display("FAIL swap_single_ack: got %0d expected 1", acks);
        end
        swap_req = 1'b1;
        while (!seen && waited < 2 * HT * VT) begin
            drive(1, 0);
            waited++;
            e = exp_vec(th, tv, 1, swap_req);
            vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL swap_wait h=%0d v=%0d: got %h expected %h", th, tv, obs, e);
            end
            if (swap_ack) seen = 1;
        end
        swap_req = 1'b0;
        vectors++;
        if (!seen || waited != (VT - (VA + VF + VS + 1) + VA) * HT) begin
            miscompares++;
            $display("FAIL swap_full_frame_wait: got ack=%0d after %0d ticks expected 1 after %0d",
                     seen, waited, (VT - (VA + VF + VS + 1) + VA) * HT);
        end
    endtask

    task automatic test_back_to_back();
        logic [26:0] e;
        for (int i = 0; i < HT + 3; i++) begin
            drive(1, 0);
            e = exp_vec(th, tv, 1, 0);
            vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL b2b h=%0d v=%0d: got %h expected %h", th, tv, obs, e);
            end
        end
    endtask

    task automatic test_stall();
        logic [26:0] e;
        while (th != 4) drive(1, 0);
        for (int i = 0; i < 20; i++) begin
            drive(0, 0);
            e = exp_vec(th, tv, 0, 0);
            vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL stall_hold cycle %0d: got %h expected %h", i, obs, e);
            end
        end
        drive(1, 0);
        e = exp_vec(th, tv, 1, 0);
        vectors++;
        if (obs !== e) begin
            miscompares++;
            $display("FAIL stall_resume: got %h expected %h", obs, e);
        end
    endtask

    task automatic test_mid_reset();
        while (!(th == 5 && tv == 3)) drive(1, 0);
        swap_req = 1'b1;
        drive(1, 1);
        vectors++;
        if (obs !== RST_VEC) begin
            miscompares++;
            $display("FAIL mid_reset: got %h expected %h", obs, RST_VEC);
        end
        swap_req = 1'b0;
        drive(1, 0);
        vectors++;
        if (obs !== FIRST_VEC) begin
            miscompares++;
            $display("FAIL reset_then_frame_start: got %h expected %h", obs, FIRST_VEC);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_frame();
        test_swap();
        test_back_to_back();
        test_stall();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Generates 640x480@60 VGA raster timing on the 50 MHz system clock, advanced by a one-cycle pixel strobe from the 25 MHz divider stage. Drives hsync/vsync to the DAC pins, pixel coordinates and an active flag to the frame-buffer read path, and arbitrates buffer swaps from the renderer so they only take effect at vertical-blank entry. It is the consumer of the pixel-rate divider and the producer of all raster timing in the triple-buffer display pipeline.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- clk_in  in  1  system clock, 50 MHz; one clock, all logic on rising edge
- reset  in  1  synchronous, active-high; sampled on clk_in rising edge
- pix_tick  in  1  one-cycle pixel enable; nominally every 2nd clk_in cycle
- swap_req  in  1  renderer requests buffer swap; level, held until swap_ack
- hsync  out  1  horizontal sync, active-low
- vsync  out  1  vertical sync, active-low
- active  out  1  current pixel is in visible area
- x  out  10  horizontal pixel coordinate
- y  out  10  vertical line coordinate
- line_start  out  1  one-cycle pulse on entry to h=0
- frame_start  out  1  one-cycle pulse on entry to (h=0, v=0)
- vblank_start  out  1  one-cycle pulse on entry to (h=0, v=V_ACTIVE)
- swap_ack  out  1  one-cycle pulse: swap accepted at this vblank

## Operation
- H_TOTAL = sum of H params (800); V_TOTAL = sum of V params (525).
- h_cnt 0..H_TOTAL-1 increments on each pix_tick; at H_TOTAL-1 wraps to 0 and v_cnt increments; v_cnt wraps V_TOTAL-1 -> 0.
- No pix_tick: counters and level outputs hold; pulse outputs return to 0.
- hsync = 0 iff H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC; vsync likewise on v_cnt.
- active = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
- x = h_cnt when h_cnt < H_ACTIVE else 0; y = v_cnt when v_cnt < V_ACTIVE else 0.
- Swap: if swap_req = 1 in the cycle whose pix_tick produces vblank_start, swap_ack pulses in the same cycle as vblank_start. Otherwise no ack; request waits for next frame. Max one ack per frame. Renderer drops swap_req the cycle after swap_ack; a request raised mid-vblank waits a full frame.

## Timing
- All outputs registered; decode computed from next counter values so outputs change on the same edge as the counters (zero latency relative to count).
- Reset values: h_cnt = H_TOTAL-1, v_cnt = V_TOTAL-1, hsync = 1, vsync = 1, active = 0, x = 0, y = 0, all pulses 0, swap_ack = 0.
- First pix_tick after reset: (0,0), active = 1, line_start = frame_start = 1.
- Pulses last exactly one clk_in cycle regardless of pix_tick spacing.
- pix_tick coincident with reset: reset wins, tick dropped.
- Reset mid-frame: immediate return to reset values; any in-flight swap forgotten (swap_req level re-sampled at next vblank).
- Back-to-back pix_tick (every cycle) is legal; block runs at double rate.

## Structure
- Package vga_timing_pkg: default H/V constants, H_TOTAL/V_TOTAL, counter widths via $clog2.
- Sub-module vga_axis_counter (params ACTIVE, FP, SYNC, BP; inputs clk_in, reset, en; outputs count, wrap, sync_n, in_active), instantiated twice: horizontal with en = pix_tick, vertical with en = pix_tick && h_wrap.
- Swap arbitration and pulse registers live in the top.

## Test plan
- Reset, pix_tick every 2nd cycle -> first tick gives x=0, y=0, active=1, frame_start=1; next frame_start exactly 800*525*2 = 840000 clk_in cycles later.
- Count one line -> hsync low for 96 ticks starting h=656; active high for 640 ticks; line_start once per 800 ticks.
- Count one frame -> vsync low on lines 490-491; vblank_start at v=480,h=0; y held at 0 for lines 480-524.
- swap_req held from line 100 -> single swap_ack coincident with vblank_start; swap_req raised at line 500 -> no ack until next frame's v=480.
- Stall pix_tick 20 cycles mid-line -> counters/x/hsync hold; no pulse repeats.
- Assert reset at (h=300, v=200) for one cycle -> all outputs to reset values next edge; next tick yields frame_start.
